// File: rtl/temp_averager.sv
// Temperature averager: 8-sample sliding-window mean plus running min/max,
// sampling c_data once every SAMPLE_DIV clock cycles.
module temp_averager #(
    parameter int unsigned SAMPLE_DIV = 10000000
) (
    input  logic       CLK100MHZ,
    input  logic       rst,
    input  logic [7:0] c_data,
    input  logic       clear,
    output logic [7:0] avg_data,
    output logic [7:0] min_data,
    output logic [7:0] max_data,
    output logic       avg_valid,
    output logic       sample_strobe,
    output logic [3:0] fill_count
);

    localparam int unsigned CW = 24;
    localparam logic [CW-1:0] TC = CW'(SAMPLE_DIV - 1);

    logic [CW-1:0] tick_cnt;
    logic [2:0]    wr_ptr;
    logic [10:0]   sum;
    logic [7:0]    sample_buf [8];

    logic          tick;
    logic          full;
    logic [7:0]    evicted;
    logic [10:0]   sum_next;
    logic [3:0]    fill_next;

    assign tick      = (tick_cnt == TC);
    assign full      = (fill_count == 4'd8);
    // Oldest sample leaves the window only once it is full
    assign evicted   = full ? sample_buf[wr_ptr] : 8'h00;
    assign sum_next  = sum + {3'b000, c_data} - {3'b000, evicted};
    assign fill_next = full ? 4'd8 : fill_count + 4'd1;

    always_ff @(posedge CLK100MHZ or posedge rst) begin
        if (rst) begin
            tick_cnt      <= '0;
            wr_ptr        <= '0;
            sum           <= '0;
            fill_count    <= '0;
            avg_data      <= 8'h00;
            avg_valid     <= 1'b0;
            min_data      <= 8'hFF;
            max_data      <= 8'h00;
            sample_strobe <= 1'b0;
        end else if (clear) begin
            tick_cnt      <= '0;
            wr_ptr        <= '0;
            sum           <= '0;
            fill_count    <= '0;
            avg_data      <= 8'h00;
            avg_valid     <= 1'b0;
            min_data      <= 8'hFF;
            max_data      <= 8'h00;
            sample_strobe <= 1'b0;
        end else begin
            tick_cnt      <= tick ? '0 : tick_cnt + CW'(1);
            sample_strobe <= tick;
            if (tick) begin
                wr_ptr     <= wr_ptr + 3'd1;
                sum        <= sum_next;
                fill_count <= fill_next;
                avg_valid  <= (fill_next == 4'd8);
                avg_data   <= (fill_next == 4'd8) ? sum_next[10:3] : 8'h00;
                if (fill_count == 4'd0) begin
                    min_data <= c_data;
                    max_data <= c_data;
                end else begin
                    if (c_data < min_data) min_data <= c_data;
                    if (c_data > max_data) max_data <= c_data;
                end
            end
        end
    end

    // Buffer needs no reset: slots are only read after being written
    always_ff @(posedge CLK100MHZ) begin
        if (tick && !clear) sample_buf[wr_ptr] <= c_data;
    end

endmodule
